mem_bus_unit: RTL and testbench

Memory bus interface sitting directly downstream of the CPU datapath's address and write-data outputs and upstream of its read-data input. Turns the controller's per-cycle read/write requests into a req/ack external bus transaction with wait states. Posts writes through a one-entry buffer. Stalls the controller on reads and on bus contention. Aborts with a sticky error after a bounded number of wait cycles.

---
 rtl/mem_bus_unit.sv | 120 ++++++++++++
 tb/tb_mem_bus_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_unit.sv
// Memory bus interface: turns controller read/write requests into a req/ack bus transaction
// with a one-entry posted-write buffer, read stalls and a bounded-wait abort.
module mem_bus_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        ph2,
    input  logic        resetb,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [7:0]  data_in,
    output logic        stall,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_req,
    output logic        bus_we,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        timeout_err
);

    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            busy;
    logic            at_max;

    assign busy   = (state_q == StWrite) || (state_q == StRead);
    assign at_max = (wait_cnt_q == WaitMax);

    // State register
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_rd) begin
                    state_d = StRead;
                end else if (mem_wr) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus_ack || at_max) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (bus_ack || at_max) begin
                    state_d = StRdone;
                end
            end
            StRdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; bus_req decodes straight from state so reset drops it at once
    always_comb begin
        bus_req = busy;
        stall   = 1'b0;
        unique case (state_q)
            StIdle:  stall = mem_rd;
            StWrite: stall = mem_rd | mem_wr;
            StRead:  stall = 1'b1;
            StRdone: stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Counter restarts from zero on every entry to a bus state
    assign wait_cnt_d = (busy && !bus_ack && !at_max) ? wait_cnt_q + 1'b1 : '0;

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            wait_cnt_q  <= '0;
            bus_addr    <= 16'h0000;
            bus_wdata   <= 8'h00;
            bus_we      <= 1'b0;
            data_in     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (state_q == StIdle) begin
                if (mem_rd) begin
                    bus_addr <= address;
                    bus_we   <= 1'b0;
                end else if (mem_wr) begin
                    bus_addr  <= address;
                    bus_wdata <= data_out;
                    bus_we    <= 1'b1;
                end
            end
            if (state_q == StRead) begin
                if (bus_ack) begin
                    data_in <= bus_rdata;
                end else if (at_max) begin
                    data_in <= 8'hFF;
                end
            end
            if (busy && !bus_ack && at_max) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit with MAX_WAIT=15.
module tb_mem_bus_unit;

    logic        ph2;
    logic        resetb;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  data_in;
    logic        stall;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_req;
    logic        bus_we;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mem_bus_unit #(.MAX_WAIT(15)) dut (
        .ph2        (ph2),
        .resetb     (resetb),
        .address    (address),
        .data_out   (data_out),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .data_in    (data_in),
        .stall      (stall),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .timeout_err(timeout_err)
    );

    initial ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge ph2);
        #1;
    endtask

    initial begin
        int n;
        resetb    = 1'b0;
        address   = 16'h0000;
        data_out  = 8'h00;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        #2;
        check("rst_req", bus_req, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 16'h0000);
        check("rst_wdata", bus_wdata, 8'h00);
        check("rst_din", data_in, 8'h00);
        check("rst_err", timeout_err, 0);
        check("rst_stall", stall, 0);
        #6 resetb = 1'b1;
        cyc();

        // Zero-wait read
        address = 16'h1234;
        mem_rd  = 1'b1;
        #1 check("rd0_stall_n", stall, 1);
        check("rd0_req_n", bus_req, 0);
        cyc();
        bus_ack   = 1'b1;
        bus_rdata = 8'hA5;
        #1 check("rd0_req_n1", bus_req, 1);
        check("rd0_stall_n1", stall, 1);
        check("rd0_addr", bus_addr, 16'h1234);
        check("rd0_we", bus_we, 0);
        cyc();
        bus_ack = 1'b0;
        #1 check("rd0_stall_n2", stall, 0);
        check("rd0_din", data_in, 8'hA5);
        check("rd0_req_n2", bus_req, 0);
        mem_rd = 1'b0;
        cyc();
        check("rd0_req_idle", bus_req, 0);

        // Posted write followed by a contending read; write acked after 3 waits
        address  = 16'h01FF;
        data_out = 8'h3C;
        mem_wr   = 1'b1;
        #1 check("wr_nostall", stall, 0);
        cyc();
        mem_wr  = 1'b0;
        mem_rd  = 1'b1;
        address = 16'h4000;
        #1 check("wr_wdata", bus_wdata, 8'h3C);
        check("wr_we", bus_we, 1);
        check("wr_addr", bus_addr, 16'h01FF);
        for (int i = 0; i < 3; i++) begin
            check("wr_wait_req", bus_req, 1);
            check("wr_wait_stall", stall, 1);
            cyc();
        end
        bus_ack = 1'b1;
        #1 check("wr_ack_req", bus_req, 1);
        check("wr_ack_stall", stall, 1);
        cyc();
        bus_ack = 1'b0;
        #1 check("rd1_idle_req", bus_req, 0);
        check("rd1_idle_stall", stall, 1);
        cyc();
        bus_ack   = 1'b1;
        bus_rdata = 8'h5A;
        #1 check("rd1_req", bus_req, 1);
        check("rd1_we", bus_we, 0);
        check("rd1_addr", bus_addr, 16'h4000);
        check("rd1_stall", stall, 1);
        cyc();
        bus_ack = 1'b0;
        #1 check("rd1_stall_done", stall, 0);
        check("rd1_din", data_in, 8'h5A);
        check("rd1_err", timeout_err, 0);
        mem_rd = 1'b0;
        cyc();

        // Read timeout: bus_ack never arrives
        address = 16'h2222;
        mem_rd  = 1'b1;
        cyc();
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            cyc();
        end
        check("to_req_cycles", n, 16);
        check("to_din", data_in, 8'hFF);
        check("to_err", timeout_err, 1);
        check("to_stall", stall, 0);
        mem_rd = 1'b0;
        cyc();
        cyc();
        check("to_err_held", timeout_err, 1);

        // Simultaneous read and write: read wins, no write issued
        address  = 16'h0ABC;
        data_out = 8'h99;
        mem_rd   = 1'b1;
        mem_wr   = 1'b1;
        #1 check("rw_stall", stall, 1);
        cyc();
        bus_ack   = 1'b1;
        bus_rdata = 8'h11;
        #1 check("rw_we", bus_we, 0);
        check("rw_addr", bus_addr, 16'h0ABC);
        check("rw_wdata", bus_wdata, 8'h3C);
        check("rw_req", bus_req, 1);
        cyc();
        bus_ack = 1'b0;
        #1 check("rw_din", data_in, 8'h11);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        cyc();
        cyc();
        check("rw_no_write", bus_req, 0);
        check("rw_we_idle", bus_we, 0);

        // Spurious ack in IDLE
        bus_ack   = 1'b1;
        bus_rdata = 8'h77;
        cyc();
        cyc();
        check("sp_req", bus_req, 0);
        check("sp_din", data_in, 8'h11);
        check("sp_stall", stall, 0);
        bus_ack = 1'b0;

        // Reset during a read wait
        address = 16'h5555;
        mem_rd  = 1'b1;
        cyc();
        cyc();
        check("mr_req_before", bus_req, 1);
        #2 resetb = 1'b0;
        #1 check("mr_req", bus_req, 0);
        check("mr_addr", bus_addr, 16'h0000);
        check("mr_wdata", bus_wdata, 8'h00);
        check("mr_we", bus_we, 0);
        check("mr_din", data_in, 8'h00);
        check("mr_err", timeout_err, 0);
        check("mr_stall_rd", stall, 1);
        mem_rd = 1'b0;
        #1 check("mr_stall_idle", stall, 0);
        #1 resetb = 1'b1;
        cyc();
        address = 16'h0F0F;
        mem_rd  = 1'b1;
        cyc();
        bus_ack   = 1'b1;
        bus_rdata = 8'hC3;
        #1 check("fr_addr", bus_addr, 16'h0F0F);
        check("fr_req", bus_req, 1);
        cyc();
        bus_ack = 1'b0;
        #1 check("fr_din", data_in, 8'hC3);
        check("fr_err", timeout_err, 0);
        check("fr_stall", stall, 0);
        mem_rd = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
